// File: rtl/phy_link_pkg.sv
// Shared types, 8b10b disparity tables and K-code helpers for the
// 16-bit PHY lane-pair model (phy_link_model16).
package phy_link_pkg;

   // Disparity-flip lookups: dp6 indexed by (31 - d[4:0]), dp4 by (7 - d[7:5])
   localparam logic [31:0] c_dp6_table = 32'hE881_8197;
   localparam logic [7:0]  c_dp4_table = 8'h89;

   // Comma character used for byte alignment
   localparam logic [7:0]  c_k28_5 = 8'hBC;

   // Every K character the line accepts, packed one byte per slot
   localparam int          c_num_legal_k = 12;
   localparam logic [c_num_legal_k*8-1:0] c_legal_k_list = {
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
      8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
   };

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  k;
      logic        err;
   } t_line_word;

   typedef enum logic [1:0] {
      LOS    = 2'd0,
      ACQ    = 2'd1,
      SYNCED = 2'd2
   } t_sync_state;

   // Running disparity after one byte; K codes with d[1:0]!=0 are neutral
   function automatic logic f_next_disparity8(input logic       cur,
                                              input logic [7:0] d,
                                              input logic       k);
      logic dp6;
      logic dp4;
      dp6 = c_dp6_table[5'd31 - d[4:0]];
      dp4 = c_dp4_table[3'd7 - d[7:5]];
      if (k && (d[1:0] != 2'b00))
         return cur;
      return cur ^ (k ^ dp6 ^ dp4);
   endfunction

   // Running disparity after a 16-bit word, MSB byte first
   function automatic logic f_next_disparity16(input logic        cur,
                                               input logic [15:0] d,
                                               input logic [1:0]  k);
      logic mid;
      mid = f_next_disparity8(cur, d[15:8], k[1]);
      return f_next_disparity8(mid, d[7:0], k[0]);
   endfunction

   // True when the byte is one of the accepted K characters
   function automatic logic f_is_legal_k(input logic [7:0] d);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < c_num_legal_k; i++)
         if (c_legal_k_list[i*8 +: 8] == d)
            hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/phy_link_aligner.sv
// Comma aligner and sync FSM for the 16-bit line model. Tracks the comma
// lane, freezes the byte shift once SYNCED and gates the RX outputs.
module phy_link_aligner
   import phy_link_pkg::*;
#(
   parameter int g_sync_commas = 3,
   parameter int g_loss_errors = 4
) (
   input  logic        clk_ref_i,
   input  logic        rst_i,
   input  t_line_word  line_word_i,
   output logic [15:0] rx_data_o,
   output logic [1:0]  rx_k_o,
   output logic        rx_enc_err_o,
   output logic        rx_synced_o
);

   localparam int c_cnt_w = $clog2(g_sync_commas + 1);
   localparam int c_err_w = $clog2(g_loss_errors + 1);
   localparam logic [c_cnt_w-1:0] c_sync_target = c_cnt_w'(g_sync_commas);
   localparam logic [c_err_w-1:0] c_loss_target = c_err_w'(g_loss_errors);

   t_sync_state        state_q, state_d;
   logic               shift_q, shift_d;
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic [c_err_w-1:0] errcnt_q, errcnt_d;
   t_line_word         prev_p1;
   t_line_word         aligned;

   logic comma_msb;
   logic comma_lsb;
   logic any_comma;
   logic comma_lane;
   logic bad_word;

   // Comma detection on the raw line word; an errored word is never a comma
   always_comb begin
      comma_msb  = line_word_i.k[1] && (line_word_i.data[15:8] == c_k28_5);
      comma_lsb  = line_word_i.k[0] && (line_word_i.data[7:0]  == c_k28_5);
      any_comma  = !line_word_i.err && (comma_msb || comma_lsb);
      comma_lane = !comma_msb;
      bad_word   = line_word_i.err || (shift_q ? comma_msb : comma_lsb);
   end

   // Sync FSM next-state: LOS -> ACQ on a comma, ACQ -> SYNCED after enough same-lane commas
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      errcnt_d = errcnt_q;
      case (state_q)
         LOS: begin
            if (any_comma) begin
               shift_d  = comma_lane;
               cnt_d    = c_cnt_w'(1);
               errcnt_d = '0;
               state_d  = (cnt_d == c_sync_target) ? SYNCED : ACQ;
            end
         end
         ACQ: begin
            if (line_word_i.err) begin
               state_d = LOS;
            end else if (any_comma) begin
               if (comma_lane == shift_q) begin
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  shift_d = comma_lane;
                  cnt_d   = c_cnt_w'(1);
               end
               if (cnt_d == c_sync_target) begin
                  state_d  = SYNCED;
                  errcnt_d = '0;
               end
            end
         end
         SYNCED: begin
            if (bad_word) begin
               errcnt_d = errcnt_q + 1'b1;
               if (errcnt_d == c_loss_target)
                  state_d = LOS;
            end else begin
               errcnt_d = '0;
            end
         end
         default: state_d = LOS;
      endcase
   end

   // Byte-shift mux: shift=1 pairs the previous LSB byte with the current MSB byte
   always_comb begin
      aligned = line_word_i;
      if (shift_d) begin
         aligned.data = {prev_p1.data[7:0], line_word_i.data[15:8]};
         aligned.k    = {prev_p1.k[0], line_word_i.k[1]};
         aligned.err  = prev_p1.err | line_word_i.err;
      end
   end

   // FSM state, counters and previous-word register
   always_ff @(posedge clk_ref_i) begin
      if (rst_i) begin
         state_q  <= LOS;
         shift_q  <= 1'b0;
         cnt_q    <= '0;
         errcnt_q <= '0;
         prev_p1  <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         errcnt_q <= errcnt_d;
         prev_p1  <= line_word_i;
      end
   end

   // ---- output stage: RX word registered together with the sync flag ----
   always_ff @(posedge clk_ref_i) begin
      if (rst_i || (state_d != SYNCED)) begin
         rx_data_o    <= '0;
         rx_k_o       <= '0;
         rx_enc_err_o <= 1'b0;
         rx_synced_o  <= 1'b0;
      end else begin
         rx_data_o    <= aligned.data;
         rx_k_o       <= aligned.k;
         rx_enc_err_o <= aligned.err;
         rx_synced_o  <= 1'b1;
      end
   end

endmodule

// File: rtl/phy_link_model16.sv
// Cycle-based model of a 16-bit 8b10b PHY lane pair: TX disparity and
// K-code checking, a g_latency-deep line delay, then comma alignment.
// Optional macro PHY_LINK_ERR_INJECT_EN adds err_inject_i, which flips
// data bit 0 and marks the word errored as it enters the line.
module phy_link_model16
   import phy_link_pkg::*;
#(
   parameter int g_latency     = 4,
   parameter int g_sync_commas = 3,
   parameter int g_loss_errors = 4
) (
   input  logic        clk_ref_i,
   input  logic        rst_i,
   input  logic [15:0] tx_data_i,
   input  logic [1:0]  tx_k_i,
   input  logic        link_up_i,
`ifdef PHY_LINK_ERR_INJECT_EN
   input  logic        err_inject_i,
`endif
   output logic        tx_disparity_o,
   output logic        tx_enc_err_o,
   output logic [15:0] rx_data_o,
   output logic [1:0]  rx_k_o,
   output logic        rx_enc_err_o,
   output logic        rx_synced_o
);

   logic       tx_err_p0;
   t_line_word push_p0;
   t_line_word line_p1 [g_latency];

   // K-code legality check and the word entering the line (broken link sends an error word)
   always_comb begin
      tx_err_p0 = (tx_k_i[1] && !f_is_legal_k(tx_data_i[15:8])) ||
                  (tx_k_i[0] && !f_is_legal_k(tx_data_i[7:0]));
      push_p0.data = tx_data_i;
      push_p0.k    = tx_k_i;
      push_p0.err  = tx_err_p0;
      if (!link_up_i) begin
         push_p0.data = 16'h0000;
         push_p0.k    = 2'b00;
         push_p0.err  = 1'b1;
      end
`ifdef PHY_LINK_ERR_INJECT_EN
      if (err_inject_i) begin
         push_p0.data[0] = ~push_p0.data[0];
         push_p0.err     = 1'b1;
      end
`endif
   end

   // ---- TX stage: running disparity and encoding-error flag ----
   always_ff @(posedge clk_ref_i) begin
      if (rst_i) begin
         tx_disparity_o <= 1'b0;
         tx_enc_err_o   <= 1'b0;
      end else begin
         tx_disparity_o <= f_next_disparity16(tx_disparity_o, tx_data_i, tx_k_i);
         tx_enc_err_o   <= tx_err_p0;
      end
   end

   // ---- line stages: shift register, cleared on reset so nothing in flight survives ----
   always_ff @(posedge clk_ref_i) begin
      if (rst_i) begin
         for (int i = 0; i < g_latency; i++)
            line_p1[i] <= '0;
      end else begin
         line_p1[0] <= push_p0;
         for (int i = 1; i < g_latency; i++)
            line_p1[i] <= line_p1[i-1];
      end
   end

   phy_link_aligner #(
      .g_sync_commas (g_sync_commas),
      .g_loss_errors (g_loss_errors)
   ) u_aligner (
      .clk_ref_i    (clk_ref_i),
      .rst_i        (rst_i),
      .line_word_i  (line_p1[g_latency-1]),
      .rx_data_o    (rx_data_o),
      .rx_k_o       (rx_k_o),
      .rx_enc_err_o (rx_enc_err_o),
      .rx_synced_o  (rx_synced_o)
   );

endmodule

// File: tb/tb_phy_link_model16.sv
// Directed bench for phy_link_model16 with default parameters
// (latency 4, 3 commas to sync, 4 bad words to lose sync).
module tb_phy_link_model16;

   logic        clk_ref = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] tx_data = 16'h0000;
   logic [1:0]  tx_k = 2'b00;
   logic        link_up = 1'b1;
   logic        tx_disparity;
   logic        tx_enc_err;
   logic [15:0] rx_data;
   logic [1:0]  rx_k;
   logic        rx_enc_err;
   logic        rx_synced;
`ifdef PHY_LINK_ERR_INJECT_EN
   logic        err_inject = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_ref = ~clk_ref;

   phy_link_model16 dut (
      .clk_ref_i      (clk_ref),
      .rst_i          (rst),
      .tx_data_i      (tx_data),
      .tx_k_i         (tx_k),
      .link_up_i      (link_up),
`ifdef PHY_LINK_ERR_INJECT_EN
      .err_inject_i   (err_inject),
`endif
      .tx_disparity_o (tx_disparity),
      .tx_enc_err_o   (tx_enc_err),
      .rx_data_o      (rx_data),
      .rx_k_o         (rx_k),
      .rx_enc_err_o   (rx_enc_err),
      .rx_synced_o    (rx_synced)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_ref);
      #1;
   endtask

   // Present one word and let one rising edge sample it
   task automatic drv(input logic [15:0] d, input logic [1:0] k);
      tx_data = d;
      tx_k    = k;
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_disp"},   {31'd0, tx_disparity}, 32'd0);
      chk({tag, "_txerr"},  {31'd0, tx_enc_err},   32'd0);
      chk({tag, "_data"},   {16'd0, rx_data},      32'd0);
      chk({tag, "_k"},      {30'd0, rx_k},         32'd0);
      chk({tag, "_rxerr"},  {31'd0, rx_enc_err},   32'd0);
      chk({tag, "_synced"}, {31'd0, rx_synced},    32'd0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // Three MSB-lane commas, then disparity patterns; word at tick n reaches rx after tick n+4
      drv(16'hBC50, 2'b10);                                  // t1
      chk("disp_bc50", {31'd0, tx_disparity}, 32'd0);
      chk("txerr_bc50", {31'd0, tx_enc_err}, 32'd0);
      drv(16'hBC50, 2'b10);                                  // t2
      drv(16'hBC50, 2'b10);                                  // t3
      chk("disp_bc50_x3", {31'd0, tx_disparity}, 32'd0);
      drv(16'h0000, 2'b00);                                  // t4
      chk("disp_0000", {31'd0, tx_disparity}, 32'd0);
      drv(16'h0300, 2'b00);                                  // t5
      chk("disp_0300", {31'd0, tx_disparity}, 32'd1);
      chk("sync_after_1comma", {31'd0, rx_synced}, 32'd0);
      drv(16'h0000, 2'b00);                                  // t6
      chk("sync_after_2comma", {31'd0, rx_synced}, 32'd0);
      drv(16'h0000, 2'b00);                                  // t7
      chk("sync_after_3comma", {31'd0, rx_synced}, 32'd1);
      chk("rx_data_comma", {16'd0, rx_data}, 32'h0000BC50);
      chk("rx_k_comma", {30'd0, rx_k}, 32'd2);
      chk("rx_err_comma", {31'd0, rx_enc_err}, 32'd0);
      drv(16'h0000, 2'b00);                                  // t8
      chk("rx_data_t4", {16'd0, rx_data}, 32'h00000000);
      drv(16'h0000, 2'b00);                                  // t9
      chk("rx_data_t5", {16'd0, rx_data}, 32'h00000300);
      chk("disp_hold", {31'd0, tx_disparity}, 32'd1);

      // Illegal K code while synced
      drv(16'h4100, 2'b10);                                  // t10
      chk("txerr_4100", {31'd0, tx_enc_err}, 32'd1);
      chk("rxerr_not_yet", {31'd0, rx_enc_err}, 32'd0);
      chk("disp_4100", {31'd0, tx_disparity}, 32'd1);
      drv(16'h0000, 2'b00);                                  // t11
      chk("txerr_clear", {31'd0, tx_enc_err}, 32'd0);
      drv(16'h0000, 2'b00);                                  // t12
      drv(16'h0000, 2'b00);                                  // t13
      drv(16'h0000, 2'b00);                                  // t14
      chk("rxerr_4100", {31'd0, rx_enc_err}, 32'd1);
      chk("rx_data_4100", {16'd0, rx_data}, 32'h00004100);
      chk("synced_1bad", {31'd0, rx_synced}, 32'd1);
      drv(16'h0000, 2'b00);                                  // t15
      chk("synced_after_good", {31'd0, rx_synced}, 32'd1);
      chk("rxerr_good", {31'd0, rx_enc_err}, 32'd0);

      // Line down for 4 words: sync survives 3 bad words, drops on the 4th
      link_up = 1'b0;
      repeat (4) drv(16'h0000, 2'b00);                       // t16..t19
      link_up = 1'b1;
      drv(16'h0000, 2'b00);                                  // t20
      chk("synced_bad1", {31'd0, rx_synced}, 32'd1);
      drv(16'h0000, 2'b00);                                  // t21
      chk("synced_bad2", {31'd0, rx_synced}, 32'd1);
      drv(16'h0000, 2'b00);                                  // t22
      chk("synced_bad3", {31'd0, rx_synced}, 32'd1);
      chk("rxerr_bad3", {31'd0, rx_enc_err}, 32'd1);
      drv(16'h0000, 2'b00);                                  // t23
      chk("synced_bad4", {31'd0, rx_synced}, 32'd0);
      chk("rx_data_los", {16'd0, rx_data}, 32'd0);
      chk("rx_k_los", {30'd0, rx_k}, 32'd0);
      chk("rxerr_los", {31'd0, rx_enc_err}, 32'd0);

      // LSB-lane commas: sync with shift=1
      repeat (3) drv(16'h50BC, 2'b01);                       // t24..t26
      drv(16'h1234, 2'b00);                                  // t27
      drv(16'h0000, 2'b00);                                  // t28
      chk("sh1_sync_1comma", {31'd0, rx_synced}, 32'd0);
      drv(16'h0000, 2'b00);                                  // t29
      chk("sh1_sync_2comma", {31'd0, rx_synced}, 32'd0);
      drv(16'h0000, 2'b00);                                  // t30
      chk("sh1_sync_3comma", {31'd0, rx_synced}, 32'd1);
      chk("sh1_data_comma", {16'd0, rx_data}, 32'h0000BC50);
      chk("sh1_k_comma", {30'd0, rx_k}, 32'd2);
      drv(16'h0000, 2'b00);                                  // t31
      chk("sh1_data_next", {16'd0, rx_data}, 32'h0000BC12);
      chk("sh1_k_next", {30'd0, rx_k}, 32'd2);

      // Fill the line with commas, then reset mid-stream
      drv(16'h50BC, 2'b01);                                  // t32
      chk("sh1_data_3400", {16'd0, rx_data}, 32'h00003400);
      chk("sh1_k_3400", {30'd0, rx_k}, 32'd0);
      repeat (3) drv(16'h50BC, 2'b01);                       // t33..t35
      chk("synced_pre_rst", {31'd0, rx_synced}, 32'd1);
      rst = 1'b1;
      drv(16'h0000, 2'b00);
      chk_all_zero("midrst");
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drv(16'h0000, 2'b00);
         chk("post_rst_synced", {31'd0, rx_synced}, 32'd0);
         chk("post_rst_data", {16'd0, rx_data}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
